// File: rtl/watch_pkg.sv
// Shared types and constants for the digital-watch input front end.
// Digit select is one-hot with hrs1 on bit 0 and sec0 on bit 5.
package watch_pkg;

   localparam int unsigned DIGIT_W = 6;

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } state_e;

   localparam logic [DIGIT_W-1:0] DIG_SEC0  = 6'b100000;
   localparam logic [DIGIT_W-1:0] DIG_SEC1  = 6'b010000;
   localparam logic [DIGIT_W-1:0] DIG_MIN0  = 6'b001000;
   localparam logic [DIGIT_W-1:0] DIG_MIN1  = 6'b000100;
   localparam logic [DIGIT_W-1:0] DIG_HRS0  = 6'b000010;
   localparam logic [DIGIT_W-1:0] DIG_HRS1  = 6'b000001;
   localparam logic [DIGIT_W-1:0] DIG_NONE  = 6'b000000;
   localparam logic [DIGIT_W-1:0] DIG_FIRST = DIG_HRS1;

   // Debounced single-cycle press pulses, one per button.
   typedef struct packed {
      logic mode;
      logic sel;
      logic up;
      logic down;
   } btn_t;

   // Advance edit cursor hrs1 -> hrs0 -> ... -> sec0 -> hrs1.
   function automatic logic [DIGIT_W-1:0] digit_next(input logic [DIGIT_W-1:0] d);
      return {d[DIGIT_W-2:0], d[DIGIT_W-1]};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, level debouncer and a registered
// single-cycle pulse on each accepted press (release gives no pulse).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 60000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic             stable_dly_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count cycles the synchronised level disagrees with the accepted level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         press_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= btn_i;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         press_q      <= stable_q & ~stable_dly_q;
         cnt_q        <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/watch_input_ctrl.sv
// Watch front end: debounced buttons, RUN/SET mode FSM and the 1 Hz
// prescaler producing clock_en, digit select and up/down edit pulses.
module watch_input_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 6000000,
   parameter int unsigned DEBOUNCE_CYC = 60000
) (
   input  logic               clk_6mhz,
   input  logic               rst,
   input  logic               btn_mode,
   input  logic               btn_sel,
   input  logic               btn_up,
   input  logic               btn_down,
   output logic               clock_en,
   output logic [DIGIT_W-1:0] digit,
   output logic               up,
   output logic               down,
   output logic               set_mode
);

   localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

   btn_t               press;
   state_e             state_q;
   state_e             state_d;
   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;
   logic [PRE_W-1:0]   pre_q;
   logic [PRE_W-1:0]   pre_d;
   logic               clock_en_q;
   logic               clock_en_d;
   logic               up_q;
   logic               up_d;
   logic               down_q;
   logic               down_d;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
      .clk_i(clk_6mhz), .rst_ni(rst), .btn_i(btn_mode), .press_o(press.mode));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sel (
      .clk_i(clk_6mhz), .rst_ni(rst), .btn_i(btn_sel), .press_o(press.sel));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
      .clk_i(clk_6mhz), .rst_ni(rst), .btn_i(btn_up), .press_o(press.up));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
      .clk_i(clk_6mhz), .rst_ni(rst), .btn_i(btn_down), .press_o(press.down));

   // Mode press dominates sel/up/down; the tick is gated on both sides of
   // a mode change so it never coincides with an edit pulse.
   always_comb begin
      state_d    = state_q;
      digit_d    = digit_q;
      pre_d      = '0;
      clock_en_d = 1'b0;
      up_d       = 1'b0;
      down_d     = 1'b0;

      case (state_q)
         RUN: begin
            if (press.mode) begin
               state_d = SET;
               digit_d = DIG_FIRST;
            end
         end
         SET: begin
            if (press.mode) begin
               state_d = RUN;
               digit_d = DIG_NONE;
            end else if (press.sel) begin
               digit_d = digit_next(digit_q);
            end
         end
         default: begin
            state_d = RUN;
            digit_d = DIG_NONE;
         end
      endcase

      if ((state_q == SET) && !press.mode && !(press.up && press.down)) begin
         up_d   = press.up;
         down_d = press.down;
      end

      if (state_q == RUN) begin
         pre_d      = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
         clock_en_d = (pre_q == PRE_MAX) && (state_d == RUN);
      end
   end

   always_ff @(posedge clk_6mhz) begin
      if (!rst) begin
         state_q    <= RUN;
         digit_q    <= DIG_NONE;
         pre_q      <= '0;
         clock_en_q <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         digit_q    <= digit_d;
         pre_q      <= pre_d;
         clock_en_q <= clock_en_d;
         up_q       <= up_d;
         down_q     <= down_d;
      end
   end

   assign clock_en = clock_en_q;
   assign digit    = digit_q;
   assign up       = up_q;
   assign down     = down_q;
   assign set_mode = (state_q == SET);

endmodule

// File: tb/tb_watch_input_ctrl.sv
// Scoreboard bench for watch_input_ctrl: an event-level reference model
// queues expected output events, a negedge monitor pops and compares.
module tb_watch_input_ctrl;

   localparam int unsigned CLK_HZ = 10;
   localparam int unsigned DEB    = 4;
   localparam int unsigned HMAX   = 8192;

   localparam logic [3:0] BM = 4'b0001;
   localparam logic [3:0] BS = 4'b0010;
   localparam logic [3:0] BU = 4'b0100;
   localparam logic [3:0] BD = 4'b1000;

   logic       clk_6mhz = 1'b0;
   logic       rst      = 1'b0;
   logic [3:0] btn      = 4'b0;
   logic       clock_en;
   logic [5:0] digit;
   logic       up;
   logic       down;
   logic       set_mode;

   watch_input_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
      .clk_6mhz(clk_6mhz),
      .rst     (rst),
      .btn_mode(btn[0]),
      .btn_sel (btn[1]),
      .btn_up  (btn[2]),
      .btn_down(btn[3]),
      .clock_en(clock_en),
      .digit   (digit),
      .up      (up),
      .down    (down),
      .set_mode(set_mode)
   );

   always #5 clk_6mhz = ~clk_6mhz;

   typedef struct {
      int         cyc;
      logic       ce;
      logic       up;
      logic       dn;
      logic       sm;
      logic [5:0] dig;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   edge_n   = 0;
   logic edge_rst = 1'b0;
   bit   started  = 1'b0;

   // Reference model state: raw input history, accepted levels, pending
   // press actions, mode, cursor position and prescaler anchor edge.
   bit   raw_hist[4][HMAX];
   int   last_rst = 0;
   bit   stable_m[4];
   int   act_edge[4];
   bit   set_m    = 1'b0;
   int   idx_m    = 0;
   int   anchor   = 0;
   exp_t prev_exp;

   // Level the debouncer sees at edge e: raw input two edges earlier,
   // forced low while the synchroniser refills after a reset.
   function automatic bit sample(int b, int e);
      if (e < 2 || e - 2 <= last_rst) return 1'b0;
      return raw_hist[b][e-2];
   endfunction

   task automatic tick();
      exp_t cur;
      bit   mode_p, sel_p, up_p, dn_p, set_b, flip;
      @(posedge clk_6mhz);
      #1;
      edge_n++;
      edge_rst = rst;
      started  = 1'b1;
      for (int b = 0; b < 4; b++) raw_hist[b][edge_n] = btn[b];
      cur = '{cyc: edge_n, ce: 1'b0, up: 1'b0, dn: 1'b0, sm: 1'b0, dig: 6'b0};
      if (!rst) begin
         last_rst = edge_n;
         anchor   = edge_n;
         set_m    = 1'b0;
         idx_m    = 0;
         for (int b = 0; b < 4; b++) begin
            stable_m[b] = 1'b0;
            act_edge[b] = -1;
         end
      end else begin
         mode_p = (act_edge[0] == edge_n);
         sel_p  = (act_edge[1] == edge_n);
         up_p   = (act_edge[2] == edge_n);
         dn_p   = (act_edge[3] == edge_n);
         set_b  = set_m;
         cur.up = set_b && up_p && !dn_p && !mode_p;
         cur.dn = set_b && dn_p && !up_p && !mode_p;
         if (mode_p) begin
            set_m = !set_b;
            idx_m = 0;
         end else if (set_b && sel_p) begin
            idx_m = (idx_m + 1) % 6;
         end
         if (set_b && !set_m) anchor = edge_n;
         cur.ce = !set_b && !set_m && (edge_n > anchor) &&
                  ((edge_n - anchor) % int'(CLK_HZ) == 0);
         // A level is accepted after DEB consecutive disagreeing samples;
         // the press acts on the FSM two edges after acceptance.
         for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            for (int j = 0; j < int'(DEB); j++) begin
               if (edge_n - j <= last_rst || sample(b, edge_n - j) == stable_m[b]) flip = 1'b0;
            end
            if (flip) begin
               stable_m[b] = !stable_m[b];
               if (stable_m[b]) act_edge[b] = edge_n + 2;
            end
         end
      end
      cur.sm  = set_m;
      cur.dig = set_m ? 6'(1 << idx_m) : 6'b0;
      if (cur.ce || cur.up || cur.dn || cur.sm != prev_exp.sm ||
          cur.dig != prev_exp.dig || !rst)
         exp_q.push_back(cur);
      prev_exp = cur;
   endtask

   task automatic drive(input logic [3:0] b, input int n);
      btn = b;
      repeat (n) tick();
   endtask

   logic [5:0] prev_dig = 6'b0;
   logic       prev_sm  = 1'b0;

   always @(negedge clk_6mhz) begin : monitor
      bit   ev;
      exp_t x;
      if (started) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            x = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_event cyc=%0d: got no event, required ce=%0b up=%0b dn=%0b sm=%0b dig=%b",
                     x.cyc, x.ce, x.up, x.dn, x.sm, x.dig);
         end
         ev = clock_en || up || down || (digit != prev_dig) || (set_mode != prev_sm) || !edge_rst;
         if (ev) begin
            n_cmp++;
            if (exp_q.size() == 0 || exp_q[0].cyc != edge_n) begin
               n_err++;
               $display("FAIL unexpected_event cyc=%0d: got ce=%0b up=%0b dn=%0b sm=%0b dig=%b, required no event",
                        edge_n, clock_en, up, down, set_mode, digit);
            end else begin
               x = exp_q.pop_front();
               if (clock_en !== x.ce || up !== x.up || down !== x.dn ||
                   set_mode !== x.sm || digit !== x.dig) begin
                  n_err++;
                  $display("FAIL outputs cyc=%0d: got ce=%0b up=%0b dn=%0b sm=%0b dig=%b, required ce=%0b up=%0b dn=%0b sm=%0b dig=%b",
                           edge_n, clock_en, up, down, set_mode, digit,
                           x.ce, x.up, x.dn, x.sm, x.dig);
               end
            end
         end
         if (set_mode) begin
            n_cmp++;
            if (!$onehot(digit)) begin
               n_err++;
               $display("FAIL digit_onehot cyc=%0d: got dig=%b, required exactly one bit set", edge_n, digit);
            end
         end
         prev_dig = digit;
         prev_sm  = set_mode;
      end
   end

   initial begin
      int         hold[4];
      logic [3:0] lvl;
      prev_exp = '{cyc: 0, ce: 1'b0, up: 1'b0, dn: 1'b0, sm: 1'b0, dig: 6'b0};
      for (int b = 0; b < 4; b++) begin
         act_edge[b] = -1;
         stable_m[b] = 1'b0;
         hold[b]     = 0;
      end
      lvl = 4'b0;

      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      drive(4'b0, 35);

      drive(BU, 20);
      drive(4'b0, 5);
      drive(BM, 10);
      drive(4'b0, 10);

      repeat (6) begin
         drive(BS, 6);
         drive(4'b0, 6);
      end

      for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? BU : 4'b0, 2);
      drive(BU, 10);
      drive(4'b0, 8);
      drive(BU | BD, 10);
      drive(4'b0, 8);
      drive(BD, 10);
      drive(4'b0, 8);

      drive(BM, 10);
      drive(4'b0, 30);

      drive(BM, 10);
      drive(4'b0, 8);
      drive(BM | BU, 3);
      rst = 1'b0;
      btn = 4'b0;
      tick();
      rst = 1'b1;
      drive(4'b0, 15);

      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 4; b++) begin
            if (hold[b] == 0) begin
               lvl[b]  = 1'($urandom_range(0, 1));
               hold[b] = int'($urandom_range(1, 12));
            end
            hold[b]--;
         end
         rst = ($urandom_range(0, 299) != 0);
         btn = lvl;
         tick();
      end
      rst = 1'b1;
      drive(4'b0, 20);

      #10;
      while (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL leftover_event cyc=%0d: got no event, required ce=%0b up=%0b dn=%0b sm=%0b dig=%b",
                  x.cyc, x.ce, x.up, x.dn, x.sm, x.dig);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
